// File: rtl/alu_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and the shift kinds
// carried by the iterative shifter.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLT    = 4'd5,
        OP_SLTU   = 4'd6,
        OP_SLL    = 4'd7,
        OP_SRL    = 4'd8,
        OP_SRA    = 4'd9,
        OP_PASS_A = 4'd10,
        OP_PASS_B = 4'd11
    } alu_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_e;

endpackage

// File: rtl/alu_stage_iter_shifter.sv
// Multi-cycle shifter: moves the accumulator by at most STEP bits per step and
// flags the step that consumes the last remaining bits.
module iter_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  shift_kind_e      kind_in,
    input  logic [WIDTH-1:0] data,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    // Six bits so that STEP=32 is representable in the compare.
    localparam int CW = 6;

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    rem;
    shift_kind_e      kind;
    logic [CW-1:0]    amt;

    always_comb begin
        amt = (rem > CW'(STEP)) ? CW'(STEP) : rem;
        case (kind)
            SK_SLL:  value = acc << amt;
            SK_SRL:  value = acc >> amt;
            default: value = $signed(acc) >>> amt;
        endcase
        done = (rem <= CW'(STEP));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            rem  <= '0;
            kind <= SK_SLL;
        end else if (load) begin
            acc  <= data;
            rem  <= CW'(shamt);
            kind <= kind_in;
        end else if (step) begin
            acc  <= value;
            rem  <= rem - amt;
        end
    end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shifter that stalls the
// front of the pipe while busy. All outputs are registered except stall.
module alu_stage #(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_enable,
    input  logic            op_valid,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] pre_alu_a,
    input  logic [XLEN-1:0] pre_alu_b,
    output logic [XLEN-1:0] alu_result,
    output logic            result_valid,
    output logic            result_zero,
    output logic            stall
);
    import alu_pkg::*;

    alu_state_e      state;
    alu_op_e         op;
    logic [4:0]      shamt;
    logic            is_shift;
    logic            start_shift;
    shift_kind_e     sh_kind;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] sh_value;
    logic            sh_done;
    logic            sh_load;
    logic            sh_step;

    always_comb begin
        op       = alu_op_e'(alu_op);
        shamt    = pre_alu_b[4:0];
        is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
        sh_kind  = (op == OP_SLL) ? SK_SLL : (op == OP_SRL) ? SK_SRL : SK_SRA;
        // Zero-amount shifts fall through here and complete in one cycle.
        comb_res = '0;
        case (op)
            OP_ADD:    comb_res = pre_alu_a + pre_alu_b;
            OP_SUB:    comb_res = pre_alu_a - pre_alu_b;
            OP_AND:    comb_res = pre_alu_a & pre_alu_b;
            OP_OR:     comb_res = pre_alu_a | pre_alu_b;
            OP_XOR:    comb_res = pre_alu_a ^ pre_alu_b;
            OP_SLT:    comb_res = XLEN'($signed(pre_alu_a) < $signed(pre_alu_b));
            OP_SLTU:   comb_res = XLEN'(pre_alu_a < pre_alu_b);
            OP_SLL:    comb_res = pre_alu_a << shamt;
            OP_SRL:    comb_res = pre_alu_a >> shamt;
            OP_SRA:    comb_res = $signed(pre_alu_a) >>> shamt;
            OP_PASS_A: comb_res = pre_alu_a;
            OP_PASS_B: comb_res = pre_alu_b;
            default:   comb_res = '0;
        endcase
    end

    assign start_shift = op_valid && is_shift && (shamt != 5'd0);
    assign sh_load     = clk_enable && (state == IDLE) && start_shift;
    assign sh_step     = clk_enable && (state == SHIFT);
    assign stall       = (state == SHIFT);

    iter_shifter #(
        .WIDTH (XLEN),
        .STEP  (SHIFT_STEP)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (sh_load),
        .step    (sh_step),
        .kind_in (sh_kind),
        .data    (pre_alu_a),
        .shamt   (shamt),
        .value   (sh_value),
        .done    (sh_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_result   <= '0;
            result_valid <= 1'b0;
            result_zero  <= 1'b1;
        end else if (clk_enable) begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_shift) begin
                        state <= SHIFT;
                    end else if (op_valid) begin
                        alu_result   <= comb_res;
                        result_zero  <= (comb_res == '0);
                        result_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        alu_result   <= sh_value;
                        result_zero  <= (sh_value == '0);
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Random and directed checks of alu_stage at SHIFT_STEP 1 and 4 against a
// plain-arithmetic reference model.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] r1, r4;
    logic        rv1, rv4, z1, z4, s1, s4;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    alu_stage #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_enable(en), .op_valid(v1), .alu_op(op),
        .pre_alu_a(a), .pre_alu_b(b), .alu_result(r1), .result_valid(rv1),
        .result_zero(z1), .stall(s1));

    alu_stage #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clk_enable(en), .op_valid(v4), .alu_op(op),
        .pre_alu_a(a), .pre_alu_b(b), .alu_result(r4), .result_valid(rv4),
        .result_zero(z4), .stall(s4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int s;
        logic [63:0] t;
        s = int'(y[4:0]);
        case (o)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6:  return (x < y) ? 32'd1 : 32'd0;
            4'd7:  return x << s;
            4'd8:  return x >> s;
            4'd9:  begin t = {{32{x[31]}}, x} >> s; return t[31:0]; end
            4'd10: return x;
            4'd11: return y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat(input logic [3:0] o, input logic [31:0] y, input int step);
        int s;
        s = int'(y[4:0]);
        if (o >= 4'd7 && o <= 4'd9 && s > 0) return 1 + (s + step - 1) / step;
        return 1;
    endfunction

    // One op on both DUTs; checks value, zero flag, latency, stall length, single pulse.
    task automatic run2(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] e, g1, g4;
        logic zz1, zz4;
        int l1, l4, st1, st4;
        e = model(o, x, y);
        l1 = 0; l4 = 0; st1 = 0; st4 = 0;
        g1 = 'x; g4 = 'x; zz1 = 1'bx; zz4 = 1'bx;
        @(negedge clk);
        op = o; a = x; b = y; v1 = 1'b1; v4 = 1'b1;
        for (int c = 1; c <= 100 && (l1 == 0 || l4 == 0); c++) begin
            @(negedge clk);
            v1 = 1'b0; v4 = 1'b0;
            if (s1) st1++;
            if (s4) st4++;
            if (rv1 && l1 == 0) begin l1 = c; g1 = r1; zz1 = z1; end
            if (rv4 && l4 == 0) begin l4 = c; g4 = r4; zz4 = z4; end
        end
        chk({tag, ".res1"}, g1, e);
        chk({tag, ".res4"}, g4, e);
        chk({tag, ".zero1"}, {31'b0, zz1}, {31'b0, e == 32'd0});
        chk({tag, ".zero4"}, {31'b0, zz4}, {31'b0, e == 32'd0});
        chk({tag, ".lat1"}, l1, lat(o, y, 1));
        chk({tag, ".lat4"}, l4, lat(o, y, 4));
        chk({tag, ".stall1"}, st1, lat(o, y, 1) - 1);
        chk({tag, ".stall4"}, st4, lat(o, y, 4) - 1);
        @(negedge clk);
        chk({tag, ".pulse"}, {30'b0, rv1, rv4}, 32'd0);
    endtask

    initial begin
        logic [31:0] snap;
        logic [3:0]  bo[3];
        logic [31:0] ba[3], bb[3];
        logic [31:0] got[$];
        int n, last, found;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.flags1", {29'b0, s1, rv1, z1}, 32'b001);
        chk("rst.res1", r1, 32'd0);
        chk("rst.flags4", {29'b0, s4, rv4, z4}, 32'b001);
        rst_n = 1'b1;

        // Directed boundary cases
        run2("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1);
        run2("sub_wrap", 4'd1, 32'd0, 32'd1);
        run2("slt", 4'd5, 32'hFFFFFFFF, 32'd1);
        run2("sltu", 4'd6, 32'hFFFFFFFF, 32'd1);
        run2("sra4", 4'd9, 32'h80000000, 32'h00000024);
        chk("sra4.const", r1, 32'hF8000000);
        run2("sll0", 4'd7, 32'h12345678, 32'd0);
        run2("illegal", 4'd13, 32'h5, 32'h7);
        run2("sll31", 4'd7, 32'h3, 32'd31);

        // Random ops
        for (int i = 0; i < 40; i++)
            run2("rnd", 4'($urandom_range(0, 15)), $urandom, $urandom);

        // Back-to-back ADD, SRL(3), OR on the STEP=1 instance
        bo = '{4'd0, 4'd8, 4'd3};
        ba = '{32'h10, 32'hF0, 32'hA0};
        bb = '{32'h5, 32'h3, 32'h0F};
        @(negedge clk);
        op = bo[0]; a = ba[0]; b = bb[0]; v1 = 1'b1; n = 1; last = 0;
        for (int c = 1; c <= 50 && got.size() < 3; c++) begin
            @(negedge clk);
            if (rv1) begin got.push_back(r1); last = c; end
            if (!s1) begin
                if (n < 3) begin op = bo[n]; a = ba[n]; b = bb[n]; n++; end
                else v1 = 1'b0;
            end
        end
        v1 = 1'b0;
        chk("b2b.count", got.size(), 3);
        chk("b2b.cycles", last, 6);
        for (int i = 0; i < 3; i++)
            chk("b2b.res", (i < got.size()) ? got[i] : 32'hx, model(bo[i], ba[i], bb[i]));

        // clk_enable freeze in the middle of SRL shamt 7
        @(negedge clk);
        op = 4'd8; a = 32'hFFFFFFFF; b = 32'd7; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b0;
        snap = r1;
        repeat (5) @(negedge clk);
        chk("frz.state", {30'b0, s1, rv1}, 32'b10);
        chk("frz.res", r1, snap);
        en = 1'b1;
        found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (rv1) found = c;
        end
        chk("frz.steps", found, 4);
        chk("frz.res_final", r1, 32'h01FFFFFF);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("frz.valid_hold", {31'b0, rv1}, 32'd1);
        en = 1'b1;
        @(negedge clk);
        chk("frz.valid_drop", {31'b0, rv1}, 32'd0);

        // Reset aborts a shift in flight
        @(negedge clk);
        op = 4'd7; a = 32'd1; b = 32'd31; v1 = 1'b1; v4 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid.flags1", {29'b0, s1, rv1, z1}, 32'b001);
        chk("rstmid.res1", r1, 32'd0);
        chk("rstmid.flags4", {29'b0, s4, rv4, z4}, 32'b001);
        chk("rstmid.res4", r4, 32'd0);
        rst_n = 1'b1;
        run2("post_rst", 4'd4, 32'hA5A5A5A5, 32'h5A5A5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
Execute stage directly downstream of the pre-ALU operand mux. It consumes the registered pre_alu_a/pre_alu_b operands together with a 4-bit ALU opcode decoded from the stage-1 microcode. Results are registered. ADD/logic/compare ops complete in a single enabled cycle. Shifts run on an iterative shifter that stalls the front of the pipe until it finishes.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
SHIFT_STEP, 1, maximum bits shifted per enabled cycle; legal values are 1, 2, 4, 8, 16, 32.

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
clk_enable  input  1  global pipeline advance; when low, all state holds
op_valid  input  1  operands and opcode are valid this cycle
alu_op  input  4  operation select (alu_op_e)
pre_alu_a  input  32  operand A from the pre-ALU stage
pre_alu_b  input  32  operand B from the pre-ALU stage
alu_result  output  32  registered result
result_valid  output  1  alu_result is new this cycle
result_zero  output  1  registered (result == 0), for branch resolve
stall  output  1  high while the iterative shift is busy; upstream holds its registers

Behaviour:
- Reset (rst_n low at posedge): the FSM goes to IDLE; alu_result=0, result_valid=0, result_zero=1 (consistent with result 0), shift counter=0, stall=0. Reset wins over clk_enable and aborts any shift in flight.
- All updates require clk_enable=1. With clk_enable=0, every register holds, including result_valid.
- Opcodes (alu_op_e): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASS_A=10, PASS_B=11. Codes 12-15 are illegal: they produce result 0 with result_valid=1.
- Arithmetic:
  - ADD/SUB are modulo 2^32.
  - SLT is a signed compare and SLTU an unsigned compare; both return {31'b0, lt}.
  - The shift amount is pre_alu_b[4:0]; the upper bits are ignored. SRA sign-fills.
- FSM states: IDLE, SHIFT.
- IDLE with op_valid=1:
  - Non-shift op: the result is registered at the next posedge, with result_valid=1 for that one enabled cycle. Latency is 1.
  - Shift with shamt=0: same as a non-shift op, result = pre_alu_a.
  - Shift with shamt>0: latch the accumulator=pre_alu_a, remaining=shamt and the shift kind, then go to SHIFT. result_valid=0.
- IDLE with op_valid=0: result_valid=0 next enabled cycle; alu_result holds its last value.
- SHIFT:
  - stall=1 (combinational from state).
  - Each enabled cycle: shift the accumulator by min(SHIFT_STEP, remaining) and decrement remaining by the same amount.
  - When remaining reaches 0 after the update: write alu_result with the shifted value, set result_valid=1, return to IDLE (stall drops the same edge).
  - Total latency from acceptance is 1 + ceil(shamt/SHIFT_STEP) enabled cycles.
  - op_valid and the operand inputs are ignored; upstream must hold them and does, because of stall.
- Back-to-back: an op presented in IDLE the cycle after a result is accepted with no bubble.
- result_zero is updated on every cycle alu_result is written, and only then.

Decomposition:
- Package alu_pkg: alu_op_e enum, the XLEN constant, and the alu_state_e {IDLE, SHIFT} typedef.
- One sub-module: iter_shifter. It holds the accumulator, remaining counter and shift kind, and exposes load / step / done. It is combinationally stepped by the parent FSM.
- Single-cycle ops stay in a case statement in alu_stage.

Test Plan:
- Reset mid-shift: SLL a=1, b=31, then rst_n low on the 3rd cycle -> next cycle stall=0, result_valid=0, alu_result=0, result_zero=1.
- ADD a=0xFFFFFFFF, b=1 -> one cycle later alu_result=0, result_zero=1, result_valid=1. SUB a=0, b=1 -> 0xFFFFFFFF.
- SLT/SLTU a=0xFFFFFFFF, b=1:
  - SLT -> 1.
  - SLTU -> 0.
- SRA a=0x80000000, b=0x00000024 (shamt 4), SHIFT_STEP=1:
  - stall is high for 4 enabled cycles.
  - The result is 0xF8000000, with a single result_valid pulse.
  - With SHIFT_STEP=4 the stall lasts 1 cycle.
- SLL with b=0 -> single-cycle result=a, and stall never asserts. Back-to-back ADD, SRL(3), OR produce three results with no extra bubbles beyond the shift stall.
- clk_enable held low for 5 cycles in the middle of SRL shamt 7 -> the counter and outputs freeze. The final result 0x01FFFFFF (a=0xFFFFFFFF) appears after 7 enabled steps.
